// File: rtl/sprite_pixel_engine.sv
// Four-slot sprite compositor around a 4-port sprite ROM.
// Three-clock pipeline: hit/address, ROM read, priority select.
module sprite_pixel_engine #(
    parameter int          SPR_W      = 16,
    parameter int          SPR_H      = 16,
    parameter int          COORD_W    = 11,
    parameter logic [23:0] TRANSP_KEY = 24'hFF00FF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_we,
    input  logic [1:0]         cfg_idx,
    input  logic [COORD_W-1:0] cfg_x,
    input  logic [COORD_W-1:0] cfg_y,
    input  logic [15:0]        cfg_base,
    input  logic               cfg_en,
    input  logic               frame_start,
    input  logic               in_valid,
    input  logic [COORD_W-1:0] in_x,
    input  logic [COORD_W-1:0] in_y,
    input  logic [23:0]        in_bg,
    input  logic               in_hsync,
    input  logic               in_vsync,
    output logic [15:0]        rom_addr0,
    output logic [15:0]        rom_addr1,
    output logic [15:0]        rom_addr2,
    output logic [15:0]        rom_addr3,
    input  logic [23:0]        rom_data0,
    input  logic [23:0]        rom_data1,
    input  logic [23:0]        rom_data2,
    input  logic [23:0]        rom_data3,
    output logic               out_valid,
    output logic [23:0]        out_rgb,
    output logic               out_hit,
    output logic [1:0]         out_slot,
    output logic               out_hsync,
    output logic               out_vsync
);

    localparam int SW_LOG = $clog2(SPR_W);
    localparam logic [COORD_W:0] SW_C = SPR_W[COORD_W:0];
    localparam logic [COORD_W:0] SH_C = SPR_H[COORD_W:0];

    logic [COORD_W-1:0] sh_x_q    [4];
    logic [COORD_W-1:0] sh_y_q    [4];
    logic [15:0]        sh_base_q [4];
    logic [3:0]         sh_en_q;
    logic [COORD_W-1:0] act_x_q   [4];
    logic [COORD_W-1:0] act_y_q   [4];
    logic [15:0]        act_base_q[4];
    logic [3:0]         act_en_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < 4; s++) begin
                sh_x_q[s]     <= '0;
                sh_y_q[s]     <= '0;
                sh_base_q[s]  <= '0;
                act_x_q[s]    <= '0;
                act_y_q[s]    <= '0;
                act_base_q[s] <= '0;
            end
            sh_en_q  <= '0;
            act_en_q <= '0;
        end else begin
            for (int s = 0; s < 4; s++) begin
                if (cfg_we && cfg_idx == 2'(s)) begin
                    sh_x_q[s]    <= cfg_x;
                    sh_y_q[s]    <= cfg_y;
                    sh_base_q[s] <= cfg_base;
                    sh_en_q[s]   <= cfg_en;
                end
                // A same-cycle write bypasses the shadow into the active set
                if (frame_start) begin
                    if (cfg_we && cfg_idx == 2'(s)) begin
                        act_x_q[s]    <= cfg_x;
                        act_y_q[s]    <= cfg_y;
                        act_base_q[s] <= cfg_base;
                        act_en_q[s]   <= cfg_en;
                    end else begin
                        act_x_q[s]    <= sh_x_q[s];
                        act_y_q[s]    <= sh_y_q[s];
                        act_base_q[s] <= sh_base_q[s];
                        act_en_q[s]   <= sh_en_q[s];
                    end
                end
            end
        end
    end

    logic [3:0]         hit_d;
    logic [15:0]        addr_d [4];
    logic [COORD_W-1:0] dx_d   [4];
    logic [COORD_W-1:0] dy_d   [4];
    logic [COORD_W:0]   px, py;

    // One extra coordinate bit keeps x+SPR_W from wrapping to the left edge
    always_comb begin
        px = {1'b0, in_x};
        py = {1'b0, in_y};
        for (int s = 0; s < 4; s++) begin
            dx_d[s]   = in_x - act_x_q[s];
            dy_d[s]   = in_y - act_y_q[s];
            hit_d[s]  = in_valid && act_en_q[s]
                     && px >= {1'b0, act_x_q[s]}
                     && px <  {1'b0, act_x_q[s]} + SW_C
                     && py >= {1'b0, act_y_q[s]}
                     && py <  {1'b0, act_y_q[s]} + SH_C;
            addr_d[s] = '0;
            if (hit_d[s])
                addr_d[s] = act_base_q[s]
                          + (16'(dy_d[s]) << SW_LOG)
                          + 16'(dx_d[s]);
        end
    end

    logic [15:0] rom_addr_q [4];
    logic [3:0]  s1_hit_q, s2_hit_q;
    logic        s1_valid_q, s2_valid_q;
    logic [23:0] s1_bg_q, s2_bg_q;
    logic        s1_hs_q, s2_hs_q, s1_vs_q, s2_vs_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < 4; s++) rom_addr_q[s] <= '0;
            s1_hit_q   <= '0;
            s1_valid_q <= 1'b0;
            s1_bg_q    <= '0;
            s1_hs_q    <= 1'b0;
            s1_vs_q    <= 1'b0;
            s2_hit_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_bg_q    <= '0;
            s2_hs_q    <= 1'b0;
            s2_vs_q    <= 1'b0;
        end else begin
            for (int s = 0; s < 4; s++) rom_addr_q[s] <= addr_d[s];
            s1_hit_q   <= hit_d;
            s1_valid_q <= in_valid;
            s1_bg_q    <= in_bg;
            s1_hs_q    <= in_hsync;
            s1_vs_q    <= in_vsync;
            s2_hit_q   <= s1_hit_q;
            s2_valid_q <= s1_valid_q;
            s2_bg_q    <= s1_bg_q;
            s2_hs_q    <= s1_hs_q;
            s2_vs_q    <= s1_vs_q;
        end
    end

    assign rom_addr0 = rom_addr_q[0];
    assign rom_addr1 = rom_addr_q[1];
    assign rom_addr2 = rom_addr_q[2];
    assign rom_addr3 = rom_addr_q[3];

    logic [23:0] rd [4];
    logic [23:0] rgb_d;
    logic        hit_o_d;
    logic [1:0]  slot_d;

    assign rd[0] = rom_data0;
    assign rd[1] = rom_data1;
    assign rd[2] = rom_data2;
    assign rd[3] = rom_data3;

    // Walk from the lowest priority up so slot 0 wins last
    always_comb begin
        rgb_d   = '0;
        hit_o_d = 1'b0;
        slot_d  = '0;
        if (s2_valid_q) begin
            rgb_d = s2_bg_q;
            for (int s = 3; s >= 0; s--) begin
                if (s2_hit_q[s] && rd[s] != TRANSP_KEY) begin
                    rgb_d   = rd[s];
                    hit_o_d = 1'b1;
                    slot_d  = 2'(s);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_rgb   <= '0;
            out_hit   <= 1'b0;
            out_slot  <= '0;
            out_hsync <= 1'b0;
            out_vsync <= 1'b0;
        end else begin
            out_valid <= s2_valid_q;
            out_rgb   <= rgb_d;
            out_hit   <= hit_o_d;
            out_slot  <= slot_d;
            out_hsync <= s2_hs_q;
            out_vsync <= s2_vs_q;
        end
    end

endmodule

// File: tb/tb_sprite_pixel_engine.sv
// Directed bench for sprite_pixel_engine with a per-slot ROM model
// that returns a programmable colour one clock after each address.
module tb_sprite_pixel_engine;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_idx = '0;
    logic [10:0] cfg_x = '0;
    logic [10:0] cfg_y = '0;
    logic [15:0] cfg_base = '0;
    logic        cfg_en = 1'b0;
    logic        frame_start = 1'b0;
    logic        in_valid = 1'b0;
    logic [10:0] in_x = '0;
    logic [10:0] in_y = '0;
    logic [23:0] in_bg = '0;
    logic        in_hsync = 1'b0;
    logic        in_vsync = 1'b0;
    logic [15:0] rom_addr0, rom_addr1, rom_addr2, rom_addr3;
    logic [23:0] rom_data0 = '0, rom_data1 = '0;
    logic [23:0] rom_data2 = '0, rom_data3 = '0;
    logic        out_valid, out_hit, out_hsync, out_vsync;
    logic [23:0] out_rgb;
    logic [1:0]  out_slot;

    logic [23:0] rom_val [4];
    int total = 0;
    int bad = 0;

    sprite_pixel_engine dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_x(cfg_x),
        .cfg_y(cfg_y), .cfg_base(cfg_base), .cfg_en(cfg_en),
        .frame_start(frame_start),
        .in_valid(in_valid), .in_x(in_x), .in_y(in_y),
        .in_bg(in_bg), .in_hsync(in_hsync), .in_vsync(in_vsync),
        .rom_addr0(rom_addr0), .rom_addr1(rom_addr1),
        .rom_addr2(rom_addr2), .rom_addr3(rom_addr3),
        .rom_data0(rom_data0), .rom_data1(rom_data1),
        .rom_data2(rom_data2), .rom_data3(rom_data3),
        .out_valid(out_valid), .out_rgb(out_rgb), .out_hit(out_hit),
        .out_slot(out_slot), .out_hsync(out_hsync),
        .out_vsync(out_vsync)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        rom_data0 <= rom_val[0];
        rom_data1 <= rom_val[1];
        rom_data2 <= rom_val[2];
        rom_data3 <= rom_val[3];
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input logic [1:0] idx, input logic [10:0] x,
                       input logic [10:0] y, input logic [15:0] base,
                       input logic en, input logic fs);
        cfg_we = 1'b1; cfg_idx = idx; cfg_x = x; cfg_y = y;
        cfg_base = base; cfg_en = en; frame_start = fs;
        tick();
        cfg_we = 1'b0; frame_start = 1'b0;
    endtask

    task automatic frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    // Leaves time at one clock after capture, where rom_addr is valid
    task automatic send(input logic [10:0] x, input logic [10:0] y,
                        input logic [23:0] bg, input logic hs);
        in_valid = 1'b1; in_x = x; in_y = y; in_bg = bg; in_hsync = hs;
        tick();
        in_valid = 1'b0; in_bg = '0; in_hsync = 1'b0;
    endtask

    task automatic to_out();
        tick();
        tick();
    endtask

    initial begin
        for (int s = 0; s < 4; s++) rom_val[s] = '0;
        #1;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_rgb", 64'(out_rgb), 64'd0);
        chk("rst_addr", {rom_addr0, rom_addr1, rom_addr2, rom_addr3}, 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        send(11'd20, 11'd20, 24'h123456, 1'b1);
        chk("bg_addr", {rom_addr0, rom_addr1, rom_addr2, rom_addr3}, 64'd0);
        to_out();
        chk("bg_valid", 64'(out_valid), 64'd1);
        chk("bg_rgb", 64'(out_rgb), 64'h123456);
        chk("bg_hit", 64'(out_hit), 64'd0);
        chk("bg_hsync", 64'(out_hsync), 64'd1);
        chk("bg_vsync", 64'(out_vsync), 64'd0);

        cfg(2'd1, 11'd100, 11'd50, 16'h0200, 1'b1, 1'b0);
        frame();
        rom_val[1] = 24'hABCDEF;
        send(11'd103, 11'd52, 24'h000001, 1'b0);
        chk("s1_addr", 64'(rom_addr1), 64'h0223);
        to_out();
        chk("s1_rgb", 64'(out_rgb), 64'hABCDEF);
        chk("s1_hit", 64'(out_hit), 64'd1);
        chk("s1_slot", 64'(out_slot), 64'd1);
        chk("s1_hsync", 64'(out_hsync), 64'd0);

        send(11'd99, 11'd52, 24'h0, 1'b0);
        chk("edge99", 64'(rom_addr1), 64'd0);
        send(11'd116, 11'd52, 24'h0, 1'b0);
        chk("edge116", 64'(rom_addr1), 64'd0);
        send(11'd115, 11'd52, 24'h0, 1'b0);
        chk("edge115", 64'(rom_addr1), 64'h022F);
        to_out();
        chk("edge115_slot", 64'(out_hit), 64'd1);

        cfg(2'd3, 11'd2040, 11'd0, 16'h1000, 1'b1, 1'b0);
        cfg(2'd2, 11'd0, 11'd0, 16'hFFF0, 1'b1, 1'b0);
        frame();
        send(11'd2047, 11'd0, 24'h0, 1'b0);
        chk("clip_in", 64'(rom_addr3), 64'h1007);
        send(11'd0, 11'd0, 24'h0, 1'b0);
        chk("clip_x0", 64'(rom_addr3), 64'd0);
        send(11'd7, 11'd0, 24'h0, 1'b0);
        chk("clip_x7", 64'(rom_addr3), 64'd0);
        send(11'd0, 11'd2, 24'h0, 1'b0);
        chk("base_wrap", 64'(rom_addr2), 64'h0010);

        cfg(2'd3, 11'd0, 11'd0, 16'h3000, 1'b1, 1'b0);
        send(11'd1, 11'd0, 24'h0, 1'b0);
        chk("shadow_only", 64'(rom_addr3), 64'd0);
        cfg(2'd3, 11'd0, 11'd0, 16'h4000, 1'b1, 1'b1);
        send(11'd1, 11'd0, 24'h0, 1'b0);
        chk("we_fs_same", 64'(rom_addr3), 64'h4001);

        cfg(2'd1, 11'd0, 11'd0, 16'h0, 1'b0, 1'b0);
        cfg(2'd0, 11'd5, 11'd5, 16'h0000, 1'b1, 1'b0);
        cfg(2'd2, 11'd8, 11'd8, 16'h0100, 1'b1, 1'b0);
        cfg(2'd3, 11'd0, 11'd0, 16'h0, 1'b0, 1'b0);
        frame();
        rom_val[0] = 24'h111111;
        rom_val[2] = 24'h222222;
        send(11'd10, 11'd10, 24'h0A0A0A, 1'b0);
        chk("ov_addr0", 64'(rom_addr0), 64'h0055);
        chk("ov_addr2", 64'(rom_addr2), 64'h0122);
        to_out();
        chk("ov_slot", 64'(out_slot), 64'd0);
        chk("ov_rgb", 64'(out_rgb), 64'h111111);
        rom_val[0] = 24'hFF00FF;
        send(11'd10, 11'd10, 24'h0A0A0A, 1'b0);
        to_out();
        chk("tr0_slot", 64'(out_slot), 64'd2);
        chk("tr0_rgb", 64'(out_rgb), 64'h222222);
        rom_val[2] = 24'hFF00FF;
        send(11'd10, 11'd10, 24'h0A0A0A, 1'b0);
        to_out();
        chk("trall_rgb", 64'(out_rgb), 64'h0A0A0A);
        chk("trall_hit", 64'(out_hit), 64'd0);
        chk("trall_slot", 64'(out_slot), 64'd0);
        tick();
        chk("idle_rgb", 64'(out_rgb), 64'd0);
        chk("idle_valid", 64'(out_valid), 64'd0);

        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_x = 11'(i); in_y = 11'd500;
            in_bg = 24'h10 + 24'(i);
            tick();
        end
        chk("strm_valid", 64'(out_valid), 64'd1);
        chk("strm_rgb", 64'(out_rgb), 64'h15);
        rst_n = 1'b0;
        #1;
        chk("mid_valid", 64'(out_valid), 64'd0);
        chk("mid_rgb", 64'(out_rgb), 64'd0);
        chk("mid_addr", {rom_addr0, rom_addr1, rom_addr2, rom_addr3}, 64'd0);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b1;
        tick();
        send(11'd10, 11'd10, 24'h777777, 1'b0);
        chk("lat1", 64'(out_valid), 64'd0);
        tick();
        chk("lat2", 64'(out_valid), 64'd0);
        tick();
        chk("lat3", 64'(out_valid), 64'd1);
        chk("lat3_rgb", 64'(out_rgb), 64'h777777);
        chk("lat3_hit", 64'(out_hit), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
